// File: rtl/axi_riscv_amo_arbiter_pkg.sv
// Shared types and sizing helpers for the AMO arbiter.
package axi_riscv_amo_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } amo_state_e;

    // Width of a requester index; never below 1 bit.
    function automatic int idx_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Width of the watchdog counter.
    function automatic int cnt_width(input int timeout_cycles);
        return (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    endfunction

endpackage

// File: rtl/axi_riscv_amo_arbiter_pick.sv
// Round-robin pick: first set request scanning upward from ptr_i with wrap.
module amo_rr_pick
    import axi_riscv_amo_arbiter_pkg::*;
#(
    parameter int NumReq = 4,
    parameter int IdxW   = idx_width(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    int k;

    // Scan offsets from far to near so the nearest set bit to ptr_i wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        k       = 0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            k = (int'(ptr_i) + i) % NumReq;
            if (req_i[k]) begin
                gnt_o    = '0;
                gnt_o[k] = 1'b1;
                idx_o    = IdxW'(k);
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_riscv_amo_arbiter.sv
// Admits one atomic operation at a time from NumReq cores, holding the grant
// until the adapter signals completion or the watchdog expires.
module axi_riscv_amo_arbiter
    import axi_riscv_amo_arbiter_pkg::*;
#(
    parameter int NumReq        = 4,
    parameter int AddrWidth     = 64,
    parameter int AtopWidth     = 6,
    parameter int TimeoutCycles = 1024,
    parameter int IdxW          = idx_width(NumReq)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
    input  logic [NumReq*AtopWidth-1:0]   req_atop_i,
    output logic                          amo_valid_o,
    input  logic                          amo_ready_i,
    output logic [AddrWidth-1:0]          amo_addr_o,
    output logic [AtopWidth-1:0]          amo_atop_o,
    output logic [IdxW-1:0]               amo_idx_o,
    input  logic                          done_i,
    output logic                          busy_o,
    output logic                          timeout_o
);

    localparam int CntW = cnt_width(TimeoutCycles);
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);

    amo_state_e           state_q, state_d;
    logic [IdxW-1:0]      ptr_q, ptr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [AtopWidth-1:0] atop_q, atop_d;
    logic [IdxW-1:0]      idx_q, idx_d;

    logic [AddrWidth-1:0] addr_arr [NumReq];
    logic [AtopWidth-1:0] atop_arr [NumReq];
    logic [NumReq-1:0]    pick_gnt;
    logic [IdxW-1:0]      pick_idx;
    logic                 pick_any;

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
        assign addr_arr[gi] = req_addr_i[gi*AddrWidth +: AddrWidth];
        assign atop_arr[gi] = req_atop_i[gi*AtopWidth +: AtopWidth];
    end

    amo_rr_pick #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_pick (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        atop_d      = atop_q;
        idx_d       = idx_q;
        req_ready_o = '0;
        timeout_o   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    req_ready_o = pick_gnt;
                    addr_d      = addr_arr[pick_idx];
                    atop_d      = atop_arr[pick_idx];
                    idx_d       = pick_idx;
                    ptr_d       = (pick_idx == IdxW'(NumReq - 1)) ? '0 : pick_idx + 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (amo_ready_i) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Completion takes priority over a coinciding expiry.
                if (done_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CntMax) begin
                    timeout_o = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            atop_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            atop_q  <= atop_d;
            idx_q   <= idx_d;
        end
    end

    assign amo_valid_o = (state_q == ST_ISSUE);
    assign busy_o      = (state_q != ST_IDLE);
    assign amo_addr_o  = addr_q;
    assign amo_atop_o  = atop_q;
    assign amo_idx_o   = idx_q;

endmodule

// File: tb/tb_axi_riscv_amo_arbiter.sv
// Scoreboard bench for the AMO arbiter: expected grants are queued at accept
// time and compared when the issued operation handshakes.
module tb_axi_riscv_amo_arbiter;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int TW = 6;
    localparam int TO = 8;

    typedef struct {
        logic [1:0]    idx;
        logic [AW-1:0] addr;
        logic [TW-1:0] atop;
    } exp_t;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [N-1:0]    req_valid_i = '0;
    logic [N-1:0]    req_ready_o;
    logic [N*AW-1:0] req_addr_i;
    logic [N*TW-1:0] req_atop_i;
    logic            amo_valid_o;
    logic            amo_ready_i = 1'b0;
    logic [AW-1:0]   amo_addr_o;
    logic [TW-1:0]   amo_atop_o;
    logic [1:0]      amo_idx_o;
    logic            done_i = 1'b0;
    logic            busy_o;
    logic            timeout_o;

    logic [AW-1:0] addr_m [N];
    logic [TW-1:0] atop_m [N];
    exp_t          sb_q [$];
    int            ptr_m = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    always #5 clk_i = ~clk_i;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign req_addr_i[gi*AW +: AW] = addr_m[gi];
        assign req_atop_i[gi*TW +: TW] = atop_m[gi];
    end

    axi_riscv_amo_arbiter #(
        .NumReq        (N),
        .AddrWidth     (AW),
        .AtopWidth     (TW),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_atop_i  (req_atop_i),
        .amo_valid_o (amo_valid_o),
        .amo_ready_i (amo_ready_i),
        .amo_addr_o  (amo_addr_o),
        .amo_atop_o  (amo_atop_o),
        .amo_idx_o   (amo_idx_o),
        .done_i      (done_i),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) begin
            if (m[(ptr_m + i) % N]) return (ptr_m + i) % N;
        end
        return 0;
    endfunction

    // Scoreboard side: compare at every issue handshake.
    always @(negedge clk_i) begin
        if (!rst_i && amo_valid_o && amo_ready_i) begin
            exp_t e;
            check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("sb_idx", 64'(amo_idx_o), 64'(e.idx));
                check("sb_addr", amo_addr_o, e.addr);
                check("sb_atop", 64'(amo_atop_o), 64'(e.atop));
            end
            $display("txn idx=%0d addr=0x%h atop=0x%h", amo_idx_o, amo_addr_o, amo_atop_o);
        end
    end

    // Called with the FSM idle, just after a rising edge. mode 0: done after
    // done_dly WAIT cycles; mode 1: watchdog expiry; mode 2: reset in WAIT.
    task automatic do_op(input logic [N-1:0] mask, input int stall, input int mode,
                         input int done_dly);
        int   w;
        exp_t e;
        req_valid_i = mask;
        amo_ready_i = (stall == 0);
        w = model_pick(mask);
        e.idx  = 2'(w);
        e.addr = addr_m[w];
        e.atop = atop_m[w];
        sb_q.push_back(e);
        @(negedge clk_i);
        check("accept_ready", 64'(req_ready_o), 64'(1) << w);
        check("accept_busy", 64'(busy_o), 64'd0);
        @(posedge clk_i); #1;
        req_valid_i = mask & ~(4'(1) << w);
        ptr_m = (w + 1) % N;
        addr_m[w] = {$urandom, $urandom};
        atop_m[w] = TW'($urandom);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk_i);
            check("bp_valid", 64'(amo_valid_o), 64'd1);
            check("bp_addr", amo_addr_o, e.addr);
            check("bp_atop", 64'(amo_atop_o), 64'(e.atop));
            check("bp_no_ready", 64'(req_ready_o), 64'd0);
            @(posedge clk_i); #1;
        end
        amo_ready_i = 1'b1;
        @(negedge clk_i);
        check("issue_valid", 64'(amo_valid_o), 64'd1);
        check("issue_busy", 64'(busy_o), 64'd1);
        @(posedge clk_i); #1;
        amo_ready_i = 1'b0;
        if (mode == 1) begin
            for (int j = 0; j < TO; j++) begin
                @(negedge clk_i);
                check("wd_timeout", 64'(timeout_o), 64'(j == TO - 1));
                check("wd_no_ready", 64'(req_ready_o), 64'd0);
                @(posedge clk_i); #1;
            end
        end else if (mode == 2) begin
            repeat (2) @(posedge clk_i);
            #1;
            rst_i = 1'b1;
            req_valid_i = '0;
            @(posedge clk_i); #1;
            rst_i = 1'b0;
            ptr_m = 0;
            @(negedge clk_i);
            check("rst_busy", 64'(busy_o), 64'd0);
            check("rst_valid", 64'(amo_valid_o), 64'd0);
            check("rst_addr", amo_addr_o, 64'd0);
            check("rst_atop", 64'(amo_atop_o), 64'd0);
            check("rst_idx", 64'(amo_idx_o), 64'd0);
            check("rst_timeout", 64'(timeout_o), 64'd0);
            @(posedge clk_i); #1;
        end else begin
            for (int j = 0; j < done_dly; j++) begin
                @(negedge clk_i);
                check("wait_busy", 64'(busy_o), 64'd1);
                check("wait_no_timeout", 64'(timeout_o), 64'd0);
                @(posedge clk_i); #1;
            end
            done_i = 1'b1;
            @(negedge clk_i);
            check("done_no_timeout", 64'(timeout_o), 64'd0);
            @(posedge clk_i); #1;
            done_i = 1'b0;
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            addr_m[k] = {$urandom, $urandom};
            atop_m[k] = TW'($urandom);
        end
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_valid", 64'(amo_valid_o), 64'd0);
        check("reset_ready", 64'(req_ready_o), 64'd0);
        check("reset_addr", amo_addr_o, 64'd0);
        check("reset_idx", 64'(amo_idx_o), 64'd0);
        check("reset_timeout", 64'(timeout_o), 64'd0);
        @(posedge clk_i); #1;

        // Fairness: all valid, grants 0,1,2,3,0.
        for (int r = 0; r < 5; r++) do_op(4'b1111, 0, 0, 1);

        // Single request from requester 2.
        addr_m[2] = 64'h1000;
        atop_m[2] = 6'h21;
        do_op(4'b0100, 0, 0, 2);

        // Backpressure with others pending.
        do_op(4'b1011, 5, 0, 0);

        // Watchdog expiry, then the next request is accepted directly.
        do_op(4'b0010, 0, 1, 0);
        do_op(4'b1000, 1, 0, 0);

        // Completion on the expiry cycle suppresses the timeout pulse.
        do_op(4'b0001, 0, 0, TO - 1);

        // Reset during WAIT, then requester 0 wins over requester 3.
        do_op(4'b0100, 0, 2, 0);
        do_op(4'b1001, 0, 0, 0);
        req_valid_i = '0;
        @(negedge clk_i);
        check("final_busy", 64'(busy_o), 64'd0);
        check("final_sb_empty", 64'(sb_q.size()), 64'd0);
        @(posedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_riscv_amo_arbiter.md
# axi_riscv_amo_arbiter

Round-robin arbiter that shares the single AMO/LR-SC execution path of the AXI RISC-V atomics adapter between `NumReq` requesting cores. It sits upstream of the adapter's slave AW port for atomic transactions. It admits exactly one atomic operation at a time and holds the grant until the adapter reports completion. A watchdog releases the grant and flags an error if completion never arrives.

## Interface
- `NumReq`, 4: number of requesters, ≥2.
- `AddrWidth`, 64: AMO address width.
- `AtopWidth`, 6: AXI5 `atop` field width.
- `TimeoutCycles`, 1024: WAIT-state watchdog limit, ≥2.
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_valid_i`  in  NumReq  per-requester request valid.
- `req_ready_o`  out  NumReq  per-requester accept; one-hot or zero.
- `req_addr_i`  in  NumReq*AddrWidth  flattened addresses; requester k occupies bits [k*AddrWidth +: AddrWidth].
- `req_atop_i`  in  NumReq*AtopWidth  flattened atop codes, same packing.
- `amo_valid_o`  out  1  issued operation valid.
- `amo_ready_i`  in  1  adapter accepts issued operation.
- `amo_addr_o`  out  AddrWidth  registered address.
- `amo_atop_o`  out  AtopWidth  registered atop.
- `amo_idx_o`  out  $clog2(NumReq)  index of the granted requester.
- `done_i`  in  1  single-cycle completion pulse from the adapter (B or last R beat).
- `busy_o`  out  1  high in ISSUE and WAIT.
- `timeout_o`  out  1  single-cycle pulse on watchdog expiry.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any `req_valid_i` is set, select winner w = first set bit scanning upward from `ptr` with wrap. Assert `req_ready_o[w]`. Capture addr/atop/idx. Set `ptr <= (w+1) mod NumReq`. Go to ISSUE.
- IDLE with no valid: all outputs idle; `ptr` unchanged.
- ISSUE: `amo_valid_o`=1. Payload is stable until the handshake. On `amo_ready_i`, go to WAIT and clear the counter.
- WAIT: count cycles.
  - On `done_i`, go to IDLE.
  - Else, if count == TimeoutCycles-1, pulse `timeout_o` and go to IDLE.
- `done_i` outside WAIT is ignored.
- `done_i` on the same cycle as expiry counts as completion; no timeout pulse.
- Requests arriving during ISSUE/WAIT are not acknowledged. Requesters must hold valid and payload until ready (AXI rule).
- A requester dropping valid while not granted is legal. A dropped request is never granted.

## Timing
- Reset values: state IDLE, `ptr`=0, counter 0, all outputs 0 (payload registers 0).
- Accept at cycle c, then `amo_valid_o` at c+1.
- `done_i` at cycle d returns the FSM to IDLE at d+1. The next accept can occur at d+1.
- Minimum period per operation: 3 cycles (accept, issue-handshake, done).
- Fairness: a continuously valid requester is granted within NumReq grants.
- `ptr` wraps from NumReq-1 to 0.
- Reset asserted mid-ISSUE/WAIT: next cycle is IDLE with all outputs 0. The abandoned operation is not reissued.

## Structure
- Package `axi_riscv_amo_arbiter_pkg`: FSM state enum, counter width as `$clog2(TimeoutCycles)`, index-width function.
- Sub-module `amo_rr_pick`: combinational rotate/priority-encode from `ptr`. Outputs a one-hot grant and its index.
- Counter, FSM and payload registers live in the top.

## Test plan
- Single request: req 2 valid with addr 0x1000, atop 0x21; ready_i=1, done 3 cycles later -> `req_ready_o`=0b0100 in cycle 0; `amo_valid_o`, addr 0x1000, idx 2 in cycle 1; `busy_o` falls after done.
- All 4 requesters valid continuously, done each time -> grant order 0,1,2,3,0 with `ptr` wrapping.
- Backpressure: `amo_ready_i` low for 5 cycles -> `amo_valid_o` and payload held stable; no new `req_ready_o`.
- Timeout with TimeoutCycles=8: no done -> `timeout_o` pulses exactly 8 cycles after the handshake; FSM returns to IDLE and the next request is accepted.
- Done coincident with expiry -> no `timeout_o` pulse.
- Reset asserted during WAIT -> all outputs 0 next cycle and `ptr`=0; a pending request from requester 0 is granted first.
